// File: rtl/trax_pkg.sv
// trax_pkg: shared entry/stack widths and the drainer state encoding.
package trax_pkg;
    localparam int DEPTH = 21;
    localparam int STACK_DEPTH = 6;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_t;
endpackage

// File: rtl/stack_drainer.sv
// stack_drainer: pops the LIFO tile stack newest-first onto a valid/ready stream.
module stack_drainer
    import trax_pkg::*;
#(
    parameter int depth = DEPTH,
    parameter int stack_depth = STACK_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [stack_depth:0] n_req,
    input  logic [depth:0]       stk_d_out,
    input  logic                 stk_empty,
    input  logic                 stk_uf,
    output logic                 stk_pop,
    output logic [depth:0]       out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic [stack_depth:0] count,
    output logic                 err
);
    drain_state_t state, state_nxt;
    logic [stack_depth:0] n_lat;
    logic quota_left, quota_hit, xfer;

    always_comb begin
        quota_hit = (n_lat != '0) && (count == n_lat);
        quota_left = (n_lat == '0) || (count < n_lat);
        xfer = out_valid && out_ready;
        // a pop only happens when the output slot is free or being emptied this cycle
        stk_pop = (state == DRAIN) && !stk_empty && !abort && quota_left && (!out_valid || out_ready);
        busy = (state == DRAIN) || (state == FLUSH);
        done = (state == DONE);
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? DRAIN : IDLE;
            DRAIN:   state_nxt = (stk_empty || quota_hit || abort) ? FLUSH : DRAIN;
            FLUSH:   state_nxt = out_valid ? FLUSH : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            n_lat <= '0;
            count <= '0;
            err <= 1'b0;
            out_data <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                n_lat <= n_req;
                count <= '0;
                err <= 1'b0;
            end else begin
                if (stk_pop)
                    count <= count + 1'b1;
                if (busy && stk_uf)
                    err <= 1'b1;
            end
            if (stk_pop) begin
                out_data <= stk_d_out;
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stack_drainer.sv
// tb_stack_drainer: drives stack_drainer against a behavioural LIFO with directed vectors.
module tb_stack_drainer;
    import trax_pkg::*;
    localparam int W = DEPTH + 1;
    localparam int CW = STACK_DEPTH + 1;

    logic clk = 1'b0;
    logic reset, start, abort, stk_empty, stk_uf, stk_pop, out_valid, out_ready, busy, done, err;
    logic [CW-1:0] n_req, count, ptr, top_idx;
    logic [W-1:0] stk_d_out, out_data, push_d;
    logic push, stk_clr, uf_force;
    logic [W-1:0] mem [64];
    int checks = 0;
    int errors = 0;

    typedef struct {
        int fill;
        int n;
        int stall;
        int exp_cnt;
        int left;
        int lat;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    assign stk_empty = (ptr == '0);
    assign top_idx = ptr - 1'b1;
    assign stk_d_out = stk_empty ? '0 : mem[top_idx[5:0]];
    assign stk_uf = uf_force;

    always @(posedge clk) begin
        if (stk_clr)
            ptr <= '0;
        else if (push) begin
            mem[ptr[5:0]] <= push_d;
            ptr <= ptr + 1'b1;
        end else if (stk_pop && !stk_empty)
            ptr <= ptr - 1'b1;
    end

    stack_drainer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .n_req(n_req),
        .stk_d_out(stk_d_out), .stk_empty(stk_empty), .stk_uf(stk_uf), .stk_pop(stk_pop),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .done(done), .count(count), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_stack(input int n);
        @(negedge clk);
        stk_clr = 1'b1;
        @(negedge clk);
        stk_clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            push = 1'b1;
            push_d = W'(16 + i);
            @(negedge clk);
        end
        push = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done) found = 1;
        end
        chk(name, 32'(found), 1);
    endtask

    task automatic drain(input vec_t v);
        int got = 0;
        int dones = 0;
        int stalled = 0;
        int done_at = 0;
        bit seen = 0;
        logic [W-1:0] held = '0;
        fill_stack(v.fill);
        n_req = CW'(v.n);
        start = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= 400 && dones == 0; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && !seen) begin
                seen = 1;
                held = out_data;
            end
            out_ready = !(seen && stalled < v.stall);
            #1;
            if (!out_ready && out_valid) begin
                stalled++;
                if (stalled > 1) chk("stall_hold", 32'(out_data), 32'(held));
                chk("stall_nopop", 32'(stk_pop), 0);
            end
            if (out_valid && out_ready) begin
                chk("order", 32'(out_data), 32'(16 + v.fill - 1 - got));
                got++;
            end
            if (stk_pop) chk("pop_nonempty", 32'(stk_empty), 0);
            if (done) begin
                dones++;
                done_at = cyc;
            end
        end
        out_ready = 1'b1;
        chk("done_seen", 32'(dones), 1);
        if (v.lat != 0) chk("done_lat", 32'(done_at), 32'(v.lat));
        chk("delivered", 32'(got), 32'(v.exp_cnt));
        chk("count", 32'(count), 32'(v.exp_cnt));
        chk("err", 32'(err), 0);
        chk("left", 32'(ptr), 32'(v.left));
        if (v.left != 0) chk("top", 32'(stk_d_out), 32'(16 + v.left - 1));
        @(negedge clk);
        #1;
        chk("done_pulse", 32'(done), 0);
        chk("busy_idle", 32'(busy), 0);
        chk("valid_idle", 32'(out_valid), 0);
        chk("count_hold", 32'(count), 32'(v.exp_cnt));
    endtask

    initial begin
        int pops;
        vecs[0] = '{fill: 5,  n: 0,  stall: 0, exp_cnt: 5,  left: 0, lat: 8};
        vecs[1] = '{fill: 5,  n: 2,  stall: 0, exp_cnt: 2,  left: 3, lat: 5};
        vecs[2] = '{fill: 3,  n: 0,  stall: 4, exp_cnt: 3,  left: 0, lat: 0};
        vecs[3] = '{fill: 0,  n: 0,  stall: 0, exp_cnt: 0,  left: 0, lat: 3};
        vecs[4] = '{fill: 64, n: 0,  stall: 0, exp_cnt: 64, left: 0, lat: 0};
        vecs[5] = '{fill: 4,  n: 10, stall: 0, exp_cnt: 4,  left: 0, lat: 0};
        vecs[6] = '{fill: 5,  n: 5,  stall: 2, exp_cnt: 5,  left: 0, lat: 0};
        reset = 1'b1;
        stk_clr = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        push = 1'b0;
        push_d = '0;
        uf_force = 1'b0;
        n_req = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_pop", 32'(stk_pop), 0);
        reset = 1'b0;
        stk_clr = 1'b0;

        foreach (vecs[i]) drain(vecs[i]);

        // abort after two pops: the held entry still drains, no further pops
        fill_stack(5);
        n_req = '0;
        start = 1'b1;
        pops = 0;
        for (int cyc = 0; cyc < 40 && pops < 2; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (stk_pop) pops++;
        end
        chk("abort_pops", 32'(pops), 2);
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort_nopop", 32'(stk_pop), 0);
        @(negedge clk);
        abort = 1'b0;
        wait_done("abort_done");
        chk("abort_count", 32'(count), 2);
        chk("abort_left", 32'(ptr), 3);

        // reset on the third pop cycle
        fill_stack(6);
        n_req = '0;
        start = 1'b1;
        pops = 0;
        for (int cyc = 0; cyc < 40 && pops < 3; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (stk_pop) pops++;
        end
        chk("mid_pops", 32'(pops), 3);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_count", 32'(count), 0);
        chk("mid_data", 32'(out_data), 0);
        chk("mid_left", 32'(ptr), 3);
        reset = 1'b0;

        // start held into DRAIN is ignored; underflow while busy sets sticky err
        fill_stack(0);
        start = 1'b1;
        @(negedge clk);
        uf_force = 1'b1;
        @(negedge clk);
        start = 1'b0;
        uf_force = 1'b0;
        @(negedge clk);
        #1;
        chk("ign_done", 32'(done), 1);
        chk("uf_err", 32'(err), 1);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("ign_idle", 32'(busy), 0);
        end
        chk("err_sticky", 32'(err), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("err_clear", 32'(err), 0);
        chk("restart_busy", 32'(busy), 1);
        wait_done("restart_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stack_drainer.md
Name: stack_drainer

Overview:
- Consumer-side controller for the LIFO tile stack.
- On `start`, pops entries from the stack one at a time and presents them, newest first, on a valid/ready output stream.
- Stops when the stack is empty or a requested number of entries has been delivered.
- Sits between the stack and the move-evaluation logic, so the stack's pop side is never driven ad hoc.

Parameters:
- depth, 21, MSB index of a stack entry (entry width = depth+1 = 22 bits).
- stack_depth, 6, log2 of stack capacity (64 entries); counters are stack_depth+1 bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a drain; sampled only in IDLE
- abort  input  1  stop popping immediately; sampled in DRAIN
- n_req  input  stack_depth+1  max entries to deliver; 0 = drain until empty; latched on start
- stk_d_out  input  depth+1  stack top-of-stack data (combinational from stack)
- stk_empty  input  1  stack empty flag
- stk_uf  input  1  stack underflow flag
- stk_pop  output  1  pop request to stack (combinational)
- out_data  output  depth+1  delivered entry (registered)
- out_valid  output  1  out_data holds an undelivered entry
- out_ready  input  1  downstream accepts out_data this cycle
- busy  output  1  high in DRAIN and FLUSH
- done  output  1  one-cycle pulse on completion
- count  output  stack_depth+1  entries popped in current/last drain
- err  output  1  sticky: stk_uf seen while busy

Behaviour:
- Reset values: state=IDLE, stk_pop=0, out_data=0, out_valid=0, busy=0, done=0, count=0, err=0, latched n_req=0.
- States: IDLE, DRAIN, FLUSH, DONE.
- IDLE:
  - On start=1: latch n_req, clear count and err, go to DRAIN.
  - out_valid stays as left by the previous drain; it is always 0 after FLUSH.
- stk_pop = (state==DRAIN) & !stk_empty & !abort & (n_lat==0 | count<n_lat) & (!out_valid | out_ready).
- On a cycle with stk_pop=1, at the same posedge:
  - out_data <= stk_d_out;
  - out_valid <= 1;
  - count <= count+1.
  - The stack decrements its pointer at that same edge.
  - Pop-to-output latency is 1 cycle.
- Output handshake:
  - A transfer occurs when out_valid & out_ready.
  - If a transfer happens without a new pop, out_valid <= 0.
  - A transfer plus pop in the same cycle gives full throughput of 1 entry/cycle.
  - out_data must stay stable while out_valid=1 and out_ready=0.
- DRAIN exits to FLUSH when stk_empty=1, or n_lat!=0 & count==n_lat, or abort=1. This is evaluated on the current cycle's values; no pop is issued that cycle.
- FLUSH: wait until out_valid=0 (last entry accepted), then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. count holds until the next start.
- start is ignored while not in IDLE.
- abort in IDLE is ignored. abort in FLUSH does not discard the held entry.
- err: set if stk_uf=1 in any cycle while busy; cleared only by reset or start. Popping never occurs with stk_empty=1, so err flags a stack/controller mismatch.
- Boundaries:
  - start with the stack already empty → DRAIN (1 cycle) → FLUSH (1 cycle) → DONE; count=0.
  - n_req greater than the stack occupancy → stops on empty.
  - count never wraps: max 2^stack_depth = 64 fits in stack_depth+1 bits.
- Reset mid-drain: all outputs return to reset values next cycle; any held entry is lost; the stack is not restored.

Decomposition:
- Shared package (trax_pkg): entry width constant (depth=21), stack_depth constant, state encoding localparams (IDLE=0, DRAIN=1, FLUSH=2, DONE=3).
- No sub-module needed; the one-entry output register stays inline.
- The bench instantiates the existing stack alongside it.

Test Plan:
- Push 5 entries 0x10..0x14, start with n_req=0, out_ready=1 → out_data 0x14,0x13,0x12,0x11,0x10 on consecutive cycles; done pulses once; count=5; stk_empty=1; err=0.
- Push 5 entries, n_req=2 → outputs 0x14,0x13 only; count=2; stack left with 3 entries and top 0x12.
- Push 3 entries, out_ready held 0 for 4 cycles after first valid → out_data=0x12 stable; stk_pop=0 during the stall; then sequence completes in order with no loss or duplication.
- Empty stack, start → no stk_pop ever; done pulses 3 cycles after start; count=0.
- Push 64 entries (full), drain all → 64 outputs, count=64 (0b1000000), no err.
- Push 6, start, assert reset on 3rd pop cycle → next cycle out_valid=0, busy=0, count=0; start on an empty stack is ignored mid-run (start pulsed in DRAIN has no effect).
